// File: rtl/button_debounce.sv
// Purpose: debounce N_BTN push-buttons on slow-clock ticks; emit clean level plus press/release/long pulses.
// Latency: btn_press rises STABLE_TICKS ticks after the first pressed sample, plus ~3 clk_in cycles of sync/tick detect.
// Backpressure: none; pulses are single-cycle and unconditional, and the consumer must sample every cycle.
module button_debounce #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 2,
  parameter int LONG_TICKS   = 8,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             tick
);

  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);
  // Raw level a released button presents; the synchronisers reset to it so
  // reset release never looks like a press.
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [N_BTN-1:0] RAW_IDLE = {N_BTN{POL}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // Synchroniser and tick-detect chain.
  logic             slow_s1_q, slow_s1_d;
  logic             slow_s2_q, slow_s2_d;
  logic             slow_s3_q, slow_s3_d;
  logic [N_BTN-1:0] btn_s1_q, btn_s1_d;
  logic [N_BTN-1:0] btn_s2_q, btn_s2_d;
  logic [N_BTN-1:0] sample;

  // Per-button debounce and hold tracking.
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [SW-1:0]    stab_cnt_q [N_BTN];
  logic [SW-1:0]    stab_cnt_d [N_BTN];
  logic [LW-1:0]    long_cnt_q [N_BTN];
  logic [LW-1:0]    long_cnt_d [N_BTN];
  state_t           state_q    [N_BTN];
  state_t           state_d    [N_BTN];

  // Next values for the synchroniser flops: plain shift chains.
  always_comb begin
    slow_s1_d = slow_clk;
    slow_s2_d = slow_s1_q;
    slow_s3_d = slow_s2_q;
    btn_s1_d  = btn_raw;
    btn_s2_d  = btn_s1_q;
  end

  // Rising edge of the synchronised slow clock; normalise buttons to pressed=1.
  assign tick   = slow_s2_q & ~slow_s3_q;
  assign sample = btn_s2_q ^ {N_BTN{POL}};

  // Debounce counters and per-button press/hold FSM.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      stab_cnt_d[i] = stab_cnt_q[i];
      long_cnt_d[i] = long_cnt_q[i];
      state_d[i]    = state_q[i];

      // Stability counter: a sample matching the current level wipes any
      // progress, so a bouncing contact never accumulates credit.
      if (tick) begin
        if (sample[i] == level_q[i]) begin
          stab_cnt_d[i] = '0;
        end else if (stab_cnt_q[i] + SW'(1) == SW'(STABLE_TICKS)) begin
          level_d[i]    = ~level_q[i];
          stab_cnt_d[i] = '0;
          press_d[i]    = ~level_q[i];
          release_d[i]  = level_q[i];
        end else begin
          stab_cnt_d[i] = stab_cnt_q[i] + SW'(1);
        end
      end

      // The accepting tick is hold tick 0; the counter freezes in LONG so
      // btn_long fires once per press. Release always wins over long.
      case (state_q[i])
        ST_IDLE: begin
          if (press_d[i]) begin
            state_d[i]    = ST_HELD;
            long_cnt_d[i] = '0;
          end
        end
        ST_HELD: begin
          if (release_d[i]) begin
            state_d[i] = ST_IDLE;
          end else if (tick) begin
            if (long_cnt_q[i] + LW'(1) == LW'(LONG_TICKS)) begin
              state_d[i]    = ST_LONG;
              long_d[i]     = 1'b1;
              long_cnt_d[i] = LW'(LONG_TICKS);
            end else begin
              long_cnt_d[i] = long_cnt_q[i] + LW'(1);
            end
          end
        end
        ST_LONG: begin
          if (release_d[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // State register; async reset drops every output at once, with no release pulse.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slow_s1_q <= 1'b0;
      slow_s2_q <= 1'b0;
      slow_s3_q <= 1'b0;
      btn_s1_q  <= RAW_IDLE;
      btn_s2_q  <= RAW_IDLE;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        stab_cnt_q[i] <= '0;
        long_cnt_q[i] <= '0;
        state_q[i]    <= ST_IDLE;
      end
    end else begin
      slow_s1_q <= slow_s1_d;
      slow_s2_q <= slow_s2_d;
      slow_s3_q <= slow_s3_d;
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        stab_cnt_q[i] <= stab_cnt_d[i];
        long_cnt_q[i] <= long_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Purpose: directed bench for button_debounce; pulse counts/tick stamps compared to hand-computed values.
// Latency: each bench tick spans 10 clk_in cycles, so every DUT effect of a tick settles inside it.
// Backpressure: none.
module tb_button_debounce;

  logic       clk_in;
  logic       rst_n;
  logic       slow_clk;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_long;
  logic       tick;

  button_debounce #(
    .N_BTN(4), .STABLE_TICKS(2), .LONG_TICKS(8), .ACTIVE_LOW(1)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .tick       (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;
  int ticks_issued = 0;
  bit clr_req = 1'b0;

  int press_n   [4];
  int release_n [4];
  int long_n    [4];
  int press_at  [4];
  int long_at   [4];
  int rel_at    [4];
  int tick_n;
  int pair_n;
  int overlap_n;
  int change_n;
  logic [3:0] level_prev;

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk_in) begin
    if (clr_req) begin
      for (int i = 0; i < 4; i++) begin
        press_n[i] = 0; release_n[i] = 0; long_n[i] = 0;
        press_at[i] = -1; long_at[i] = -1; rel_at[i] = -1;
      end
      tick_n = 0; pair_n = 0; overlap_n = 0; change_n = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_press[i])   begin press_n[i]++;   press_at[i] = ticks_issued; end
        if (btn_release[i]) begin release_n[i]++; rel_at[i]   = ticks_issued; end
        if (btn_long[i])    begin long_n[i]++;    long_at[i]  = ticks_issued; end
      end
      if (tick) tick_n++;
      if (btn_press == 4'b1001) pair_n++;
      if ((btn_press & btn_release) != 4'b0000) overlap_n++;
      if (btn_level != level_prev) change_n++;
    end
    level_prev = btn_level;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    ticks_issued = 0;
    clr_req = 1'b1;
    @(negedge clk_in);
    #1 clr_req = 1'b0;
  endtask

  // One slow_clk period: raw inputs settle, rise (the tick), fall.
  task automatic do_tick();
    repeat (2) @(negedge clk_in);
    slow_clk = 1'b1;
    ticks_issued++;
    repeat (4) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    slow_clk = 1'b0;
    btn_raw  = 4'b0000;           // every button pressed (active low)
    clear_counts();

    // Reset with buttons held: nothing may come out.
    ticks(3);
    chk("rst_level",   btn_level,   4'b0000);
    chk("rst_press",   btn_press,   4'b0000);
    chk("rst_release", btn_release, 4'b0000);
    chk("rst_long",    btn_long,    4'b0000);
    chk("rst_tick_n",  tick_n,      0);
    chk("rst_press_n", press_n[0] + press_n[3], 0);

    // Release reset with all held: press on tick 2.
    @(negedge clk_in);
    rst_n = 1'b1;
    clear_counts();
    do_tick();
    chk("t1_no_press_yet", press_n[0] + press_n[1] + press_n[2] + press_n[3], 0);
    chk("t1_tick_seen", tick_n, 1);
    do_tick();
    chk("t1_press0_n",  press_n[0], 1);
    chk("t1_press0_at", press_at[0], 2);
    chk("t1_press3_at", press_at[3], 2);
    chk("t1_level",     btn_level, 4'b1111);
    btn_raw = 4'b1111;
    ticks(2);
    chk("t1_rel_level", btn_level, 4'b0000);
    chk("t1_rel1_at",   rel_at[1], 4);

    // Clean press/release of button 0.
    clear_counts();
    btn_raw = 4'b1110;
    ticks(5);
    chk("t2_press_n",  press_n[0], 1);
    chk("t2_press_at", press_at[0], 2);
    chk("t2_level",    btn_level, 4'b0001);
    chk("t2_long_n",   long_n[0], 0);
    btn_raw = 4'b1111;
    ticks(2);
    chk("t2_rel_n",    release_n[0], 1);
    chk("t2_rel_at",   rel_at[0], 7);
    chk("t2_level0",   btn_level, 4'b0000);
    chk("t2_others",   press_n[1] + press_n[2] + press_n[3] + release_n[1] + release_n[2] + release_n[3], 0);

    // Bounce on button 1: pressed on odd ticks, released on even ticks.
    clear_counts();
    for (int k = 1; k <= 6; k++) begin
      btn_raw = (k % 2 == 1) ? 4'b1101 : 4'b1111;
      do_tick();
    end
    chk("t3_bounce_press", press_n[1], 0);
    chk("t3_bounce_level", btn_level, 4'b0000);
    btn_raw = 4'b1101;
    do_tick();
    chk("t3_one_stable", press_n[1], 0);
    do_tick();
    chk("t3_press_n",  press_n[1], 1);
    chk("t3_press_at", press_at[1], 8);
    btn_raw = 4'b1111;
    ticks(2);
    chk("t3_rel_n", release_n[1], 1);

    // Long press on button 2.
    clear_counts();
    btn_raw = 4'b1011;
    ticks(12);
    chk("t4_press_at", press_at[2], 2);
    chk("t4_long_n",   long_n[2], 1);
    chk("t4_long_at",  long_at[2], 10);
    chk("t4_level",    btn_level, 4'b0100);
    btn_raw = 4'b1111;
    ticks(2);
    chk("t4_rel_n",    release_n[2], 1);
    chk("t4_rel_at",   rel_at[2], 14);
    chk("t4_long_n2",  long_n[2], 1);

    // Simultaneous press of buttons 0 and 3, then slow_clk frozen.
    clear_counts();
    btn_raw = 4'b0110;
    ticks(2);
    chk("t5_pair",    pair_n, 1);
    chk("t5_overlap", overlap_n, 0);
    chk("t5_level",   btn_level, 4'b1001);
    clear_counts();
    btn_raw = 4'b1111;             // raw changes while no ticks arrive
    repeat (1000) @(negedge clk_in);
    chk("t5_frozen_ticks",   tick_n, 0);
    chk("t5_frozen_changes", change_n, 0);
    chk("t5_frozen_pulses",  release_n[0] + release_n[3] + press_n[1] + long_n[0], 0);
    chk("t5_frozen_level",   btn_level, 4'b1001);
    ticks(2);
    chk("t5_rel_after", release_n[0] + release_n[3], 2);
    chk("t5_level0",    btn_level, 4'b0000);

    // Reset while button 2 sits in LONG.
    clear_counts();
    btn_raw = 4'b1011;
    ticks(11);
    chk("t6_long_n", long_n[2], 1);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_level", btn_level, 4'b0000);
    chk("t6_async_press", btn_press | btn_release | btn_long, 4'b0000);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    clear_counts();
    do_tick();
    chk("t6_no_release", release_n[2], 0);
    chk("t6_no_press_yet", press_n[2], 0);
    do_tick();
    chk("t6_repress_at", press_at[2], 2);
    chk("t6_level", btn_level, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
